// File: rtl/dsp_mac_sequencer.sv
// Job controller for a DSP48A1 slice: streams a dot-product job into the slice and returns the 48-bit sum.
// A tag pipeline mirrors slice latency, so OPMODE/CEP line up with the operands they belong to.
module dsp_mac_sequencer #(
  parameter int LEN_W   = 16,
  parameter int OP_LAG  = 1,
  parameter int CEP_LAG = 2,
  parameter int P_LAG   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic [47:0]      result,
  output logic             result_valid
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam logic [7:0] OPMODE_NONE  = 8'h00;
  localparam logic [7:0] OPMODE_FIRST = 8'h01;
  localparam logic [7:0] OPMODE_ACC   = 8'h09;

  state_t           state, state_next;
  logic [LEN_W-1:0] count;
  logic             first_pending;
  tag_t             tag_pipe [1:P_LAG];
  tag_t             tag_in;
  logic             accept;
  logic             last_beat;
  logic             capture;
  logic             job_start;

  assign dsp_a   = in_a;
  assign dsp_b   = in_b;
  assign dsp_cea = 1'b1;
  assign dsp_ceb = 1'b1;
  assign dsp_cem = 1'b1;

  assign job_start = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (count == LEN_W'(1));
  assign capture   = tag_pipe[P_LAG].valid && tag_pipe[P_LAG].last;

  assign tag_in.valid = accept;
  assign tag_in.first = accept && first_pending;
  assign tag_in.last  = last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : FEED;
      FEED:    if (last_beat) state_next = DRAIN;
      DRAIN:   if (capture) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // First tag selects Z=0 so the slice's unreset P register never leaks into a new job.
  always_comb begin
    busy         = (state != IDLE);
    in_ready     = (state == FEED);
    result_valid = (state == DONE);
    dsp_cep      = tag_pipe[CEP_LAG].valid;
    dsp_opmode   = OPMODE_NONE;
    if (tag_pipe[OP_LAG].valid)
      dsp_opmode = tag_pipe[OP_LAG].first ? OPMODE_FIRST : OPMODE_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      first_pending <= 1'b0;
      result        <= '0;
      for (int i = 1; i <= P_LAG; i++) tag_pipe[i] <= '0;
    end else begin
      if (job_start) begin
        count         <= len;
        first_pending <= 1'b1;
      end else if (accept) begin
        count         <= count - LEN_W'(1);
        first_pending <= 1'b0;
      end
      tag_pipe[1] <= tag_in;
      for (int i = 2; i <= P_LAG; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (job_start && (len == '0))
        result <= '0;
      else if ((state == DRAIN) && capture)
        result <= dsp_p;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model (A1/B1, M, P and OPMODE registered).
// Expected sums, latencies and OPMODE sequences come from plain arithmetic over each job's operand list.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [17:0]      dsp_a, dsp_b;
  logic             dsp_cea, dsp_ceb, dsp_cem;
  logic [7:0]       dsp_opmode;
  logic             dsp_cep;
  logic [47:0]      dsp_p;
  logic [47:0]      result;
  logic             result_valid;

  int checks = 0;
  int errors = 0;

  dsp_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
    .dsp_opmode(dsp_opmode), .dsp_cep(dsp_cep), .dsp_p(dsp_p),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Slice model: A1/B1 -> M -> P, OPMODE registered once; X=01 selects M, Z=10 selects P feedback.
  logic [17:0] a1, b1;
  logic [35:0] m_reg;
  logic [7:0]  opmode_reg;
  logic [47:0] p_reg;
  always @(posedge clk) begin
    if (dsp_cea) a1 <= dsp_a;
    if (dsp_ceb) b1 <= dsp_b;
    if (dsp_cem) m_reg <= a1 * b1;
    opmode_reg <= dsp_opmode;
    if (dsp_cep)
      p_reg <= ((opmode_reg[3:2] == 2'b10) ? p_reg : 48'd0) +
               ((opmode_reg[1:0] == 2'b01) ? {12'd0, m_reg} : 48'd0);
  end
  assign dsp_p = p_reg;

  int         cep_count = 0;
  bit         ready_seen = 0;
  logic [7:0] opmode_log [$];
  always @(negedge clk) begin
    if (dsp_cep === 1'b1) cep_count++;
    if (in_ready === 1'b1) ready_seen = 1;
    if (dsp_opmode !== 8'h00) opmode_log.push_back(dsp_opmode);
  end

  logic [17:0] ja [$];
  logic [17:0] jb [$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [17:0] a, input logic [17:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string name, input int gap_lo, input int gap_hi, input bit mid_start);
    int          n;
    int          waited;
    int          gap;
    bit          seen;
    logic [47:0] expected_sum;
    n = ja.size();
    expected_sum = '0;
    for (int i = 0; i < n; i++) expected_sum += 48'(ja[i]) * 48'(jb[i]);

    tick();
    checkOutput({name, " idle busy"}, {63'd0, busy}, 64'd0);
    checkOutput({name, " idle result_valid"}, {63'd0, result_valid}, 64'd0);
    start = 1'b1;
    len   = LEN_W'(n);
    cep_count  = 0;
    ready_seen = 0;
    opmode_log.delete();
    tick();
    start = 1'b0;
    checkOutput({name, " busy after start"}, {63'd0, busy}, 64'd1);

    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        gap = $urandom_range(gap_hi, gap_lo);
        repeat (gap) tick();
      end
      applyStimulus(1'b1, ja[i], jb[i]);
      if (mid_start && i == 0) start = 1'b1;
      #1;
      checkOutput({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
      if (i == 0) checkOutput({name, " dsp_a copy"}, {46'd0, dsp_a}, {46'd0, ja[i]});
      tick();
      start = 1'b0;
      applyStimulus(1'b0, '0, '0);
    end

    seen   = 0;
    waited = 0;
    while (!seen && waited < 12) begin
      if (result_valid === 1'b1) seen = 1;
      else begin
        tick();
        waited++;
      end
    end
    checkOutput({name, " result_valid latency"}, 64'(waited), (n == 0) ? 64'd0 : 64'd3);
    checkOutput({name, " result"}, {16'd0, result}, {16'd0, expected_sum});
    checkOutput({name, " busy at result"}, {63'd0, busy}, 64'd1);
    checkOutput({name, " cep cycles"}, 64'(cep_count), 64'(n));
    checkOutput({name, " in_ready seen"}, {63'd0, ready_seen}, {63'd0, (n != 0)});
    checkOutput({name, " opmode count"}, 64'(opmode_log.size()), 64'(n));
    for (int i = 0; i < n && i < opmode_log.size(); i++)
      checkOutput({name, " opmode"}, {56'd0, opmode_log[i]}, (i == 0) ? 64'h01 : 64'h09);
  endtask

  initial begin
    #12;
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("reset opmode", {56'd0, dsp_opmode}, 64'd0);
    checkOutput("reset cep", {63'd0, dsp_cep}, 64'd0);
    checkOutput("reset result", {16'd0, result}, 64'd0);
    checkOutput("reset result_valid", {63'd0, result_valid}, 64'd0);
    checkOutput("ce tie", {61'd0, dsp_cea, dsp_ceb, dsp_cem}, 64'd7);
    tick();
    rst_n = 1'b1;

    ja = '{18'd1, 18'd3, 18'd5}; jb = '{18'd2, 18'd4, 18'd6};
    run_job("len3 b2b", 0, 0, 0);
    run_job("len3 gap2", 2, 2, 0);
    ja.delete(); jb.delete();
    run_job("len0", 0, 0, 0);
    ja = '{18'h3FFFF, 18'h3FFFF}; jb = '{18'h3FFFF, 18'h3FFFF};
    run_job("len2 max", 0, 0, 0);

    tick();
    start = 1'b1; len = LEN_W'(3);
    tick();
    start = 1'b0;
    applyStimulus(1'b1, 18'd1, 18'd2);
    tick();
    applyStimulus(1'b1, 18'd3, 18'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", {63'd0, busy}, 64'd0);
    checkOutput("midreset in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("midreset opmode", {56'd0, dsp_opmode}, 64'd0);
    checkOutput("midreset cep", {63'd0, dsp_cep}, 64'd0);
    checkOutput("midreset result", {16'd0, result}, 64'd0);
    checkOutput("midreset result_valid", {63'd0, result_valid}, 64'd0);
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    ja = '{18'd7}; jb = '{18'd9};
    run_job("after reset", 0, 0, 0);

    ja = '{18'd10}; jb = '{18'd10};
    run_job("job A", 0, 0, 0);
    ja = '{18'd2}; jb = '{18'd3};
    run_job("job B", 0, 0, 1);
    tick();
    checkOutput("extra start ignored", {63'd0, busy}, 64'd0);
    tick();
    checkOutput("extra start still idle", {62'd0, busy, result_valid}, 64'd0);

    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(6, 1);
      ja.delete(); jb.delete();
      for (int i = 0; i < n; i++) begin
        ja.push_back(18'($urandom_range(18'h3FFFF, 0)));
        jb.push_back(18'($urandom_range(18'h3FFFF, 0)));
      end
      run_job($sformatf("rand%0d", j), 0, 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
